// File: rtl/alu_exec_unit.sv
// alu_exec_unit: multi-cycle EX-stage ALU with valid/ready handshakes on both sides.
// Shifts advance one bit per cycle through the SHIFT state.
// Compile-time option: define ALU_FAST_SHIFT_EN to turn sll/srl into single-cycle
// barrel shifts. The SHIFT state is then never entered. Results are identical in
// both builds; only the shift latency differs.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             err
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_ctrl;
  logic [4:0]       r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_ovf;
  logic             r_err;

  logic             w_accept;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_shifted;
  logic             w_ovf;
  logic             w_err;
  logic             w_iter;

  assign w_accept  = in_valid && (r_state == S_IDLE);
  assign w_sum     = a + b;
  assign w_diff    = a - b;
  // The shift register is the result register itself. Its direction comes from the latched opcode.
  assign w_shifted = (r_ctrl == OP_SRL) ? (r_result >> 1) : (r_result << 1);

  // Single-cycle result for the incoming request. w_iter marks an iterative shift start.
  always_comb begin
    w_res  = '0;
    w_ovf  = 1'b0;
    w_err  = 1'b0;
    w_iter = 1'b0;
    case (alu_ctrl)
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff;
        w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL: w_res = b << shamt;
      OP_SRL: w_res = b >> shamt;
`else
      OP_SLL, OP_SRL: begin
        w_res  = b;
        w_iter = (shamt != '0);
      end
`endif
      default: w_err = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_iter ? S_SHIFT : S_DONE;
      S_SHIFT: if (r_cnt == 5'd1) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the state and the result registers
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
    result    = r_result;
    zero      = r_zero;
    ovf       = r_ovf;
    err       = r_err;
  end

  // Datapath: latch on accept, shift in SHIFT, hold in DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ctrl   <= alu_ctrl;
            r_cnt    <= w_iter ? shamt : '0;
            r_result <= w_res;
            r_zero   <= (w_res == '0);
            r_ovf    <= w_ovf;
            r_err    <= w_err;
          end
        end
        S_SHIFT: begin
          r_result <= w_shifted;
          r_cnt    <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) r_zero <= (w_shifted == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: hand-computed vectors, latency, backpressure, reset abort.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        ovf;
  logic        err;

  int checks   = 0;
  int failures = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .a(a), .b(b), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int shift_lat(input int n);
`ifdef ALU_FAST_SHIFT_EN
    return 1;
`else
    return (n == 0) ? 1 : n + 1;
`endif
  endfunction

  // Present one request at a falling edge and count falling edges until out_valid.
  // busy reports whether in_ready stayed low while waiting.
  task automatic issue(input logic [3:0] c, input logic [31:0] av, input logic [31:0] bv,
                       input logic [4:0] sh, output int lat, output logic busy);
    alu_ctrl = c; a = av; b = bv; shamt = sh; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat  = 1;
    busy = 1'b1;
    while (!out_valid && lat < 64) begin
      if (in_ready) busy = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (in_ready) busy = 1'b0;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int   lat;
    logic busy;
    logic hold_ok;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_ctrl = '0; a = '0; b = '0; shamt = '0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {29'd0, zero, ovf, err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // add with signed overflow
    issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, lat, busy);
    chk("add_lat", lat, 32'd1);
    chk("add_result", result, 32'h8000_0000);
    chk("add_flags", {29'd0, zero, ovf, err}, 32'b010);
    chk("add_in_ready", {31'd0, in_ready}, 32'd0);
    release_out();

    // sub of equal operands
    issue(4'b0110, 32'h1234_5678, 32'h1234_5678, 5'd0, lat, busy);
    chk("sub_eq_result", result, 32'd0);
    chk("sub_eq_flags", {29'd0, zero, ovf, err}, 32'b100);
    release_out();

    // sub with overflow: most negative minus one
    issue(4'b0110, 32'h8000_0000, 32'h0000_0001, 5'd0, lat, busy);
    chk("sub_ovf_result", result, 32'h7FFF_FFFF);
    chk("sub_ovf_flags", {29'd0, zero, ovf, err}, 32'b010);
    release_out();

    // slt, both orders
    issue(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, lat, busy);
    chk("slt_true", result, 32'd1);
    chk("slt_true_ovf", {31'd0, ovf}, 32'd0);
    release_out();
    issue(4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, lat, busy);
    chk("slt_false", result, 32'd0);
    chk("slt_false_zero", {31'd0, zero}, 32'd1);
    release_out();

    // and / or
    issue(4'b0000, 32'hFF00_F0F0, 32'h0FF0_3C3C, 5'd0, lat, busy);
    chk("and_result", result, 32'h0F00_3030);
    release_out();
    issue(4'b0001, 32'hFF00_F0F0, 32'h0FF0_3C3C, 5'd0, lat, busy);
    chk("or_result", result, 32'hFFF0_FCFC);
    release_out();

    // srl by 31
    issue(4'b1001, 32'hDEAD_BEEF, 32'h8000_0000, 5'd31, lat, busy);
    chk("srl31_lat", lat, shift_lat(31));
    chk("srl31_busy", {31'd0, busy}, 32'd1);
    chk("srl31_result", result, 32'h0000_0001);
    chk("srl31_flags", {29'd0, zero, ovf, err}, 32'b000);
    release_out();

    // sll by 4 with backpressure; new requests during the hold are ignored
    issue(4'b1000, 32'h0, 32'h0000_0001, 5'd4, lat, busy);
    chk("sll4_lat", lat, shift_lat(4));
    hold_ok = 1'b1;
    alu_ctrl = 4'b0001; a = 32'hFFFF_FFFF; b = 32'h0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(out_valid === 1'b1 && result === 32'h10 && in_ready === 1'b0)) hold_ok = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("hold_stable", {31'd0, hold_ok}, 32'd1);
    chk("hold_result", result, 32'h0000_0010);
    release_out();

    // back-to-back request right after the handshake
    issue(4'b0010, 32'd100, 32'd23, 5'd0, lat, busy);
    chk("b2b_result", result, 32'd123);
    release_out();

    // invalid opcode
    issue(4'b1111, 32'h1234, 32'h5678, 5'd3, lat, busy);
    chk("inv_lat", lat, 32'd1);
    chk("inv_result", result, 32'd0);
    chk("inv_flags", {29'd0, zero, ovf, err}, 32'b101);
    release_out();

    // shift by zero passes b through in one cycle
    issue(4'b1000, 32'h0, 32'h0000_00A5, 5'd0, lat, busy);
    chk("sh0_lat", lat, 32'd1);
    chk("sh0_result", result, 32'h0000_00A5);
    chk("sh0_err", {31'd0, err}, 32'd0);
    release_out();

    // reset during a long shift aborts it
    alu_ctrl = 4'b1000; a = '0; b = 32'h0000_0003; shamt = 5'd20; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
`ifndef ALU_FAST_SHIFT_EN
    chk("midshift_busy", {31'd0, in_ready}, 32'd0);
`endif
    reset = 1'b1;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    issue(4'b0000, 32'h0000_00F0, 32'h0000_003C, 5'd0, lat, busy);
    chk("post_rst_lat", lat, 32'd1);
    chk("post_rst_and", result, 32'h0000_0030);
    release_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
